// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Common data bus arbiter for four result producers (0=alu, 1=muldiv,
//   2=lsq, 3=br). Each producer owns one holding entry. A result accepted at
//   a clock edge sits in its holding entry and can be broadcast from the
//   following cycle onward. One entry per cycle wins the bus. A winning
//   entry may be refilled at the same edge it drains, so one producer with
//   no competitors streams one result per cycle.
//
// Configuration:
//   CDB_ARB_RR_EN  undefined -> fixed priority, highest source index wins
//                  defined   -> round-robin, search starts at a pointer and
//                               goes upward mod 4; the pointer moves to
//                               winner+1 after every broadcast
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (priority over all)
//   flush       in   mispredict flush: no grant/accept, all holds dropped
//   req_valid   in   [3:0] per-source result valid
//   req_pd      in   [4*PD_W-1:0]   per-source physical destination tag
//   req_rd      in   [4*5-1:0]      per-source architectural destination
//   req_rob     in   [4*ROB_W-1:0]  per-source ROB index
//   req_result  in   [4*DATA_W-1:0] per-source result data
//   req_ready   out  [3:0] source may present a result this cycle
//   cdb_valid   out  broadcast valid
//   cdb_pd      out  [PD_W-1:0]   broadcast tag (0 when idle)
//   cdb_rd      out  [4:0]        broadcast rd (0 when idle)
//   cdb_rob     out  [ROB_W-1:0]  broadcast ROB index (0 when idle)
//   cdb_result  out  [DATA_W-1:0] broadcast data (0 when idle)
//   cdb_src     out  [1:0]        broadcasting source (0 when idle)
//   cdb_sent    out  [3:0] one-hot, source broadcast this cycle
//   stall_cnt   out  [4*16-1:0] per-source saturating lost-arbitration count
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int PD_W   = 6,
  parameter int ROB_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [3:0]          req_valid,
  input  logic [4*PD_W-1:0]   req_pd,
  input  logic [4*5-1:0]      req_rd,
  input  logic [4*ROB_W-1:0]  req_rob,
  input  logic [4*DATA_W-1:0] req_result,
  output logic [3:0]          req_ready,
  output logic                cdb_valid,
  output logic [PD_W-1:0]     cdb_pd,
  output logic [4:0]          cdb_rd,
  output logic [ROB_W-1:0]    cdb_rob,
  output logic [DATA_W-1:0]   cdb_result,
  output logic [1:0]          cdb_src,
  output logic [3:0]          cdb_sent,
  output logic [4*16-1:0]     stall_cnt
);

  // Holding entries
  logic [3:0]        hold_v_q;
  logic [3:0]        hold_v_d;
  logic [PD_W-1:0]   hold_pd_q     [4];
  logic [4:0]        hold_rd_q     [4];
  logic [ROB_W-1:0]  hold_rob_q    [4];
  logic [DATA_W-1:0] hold_result_q [4];

  // Unpacked views of the packed request payloads
  logic [PD_W-1:0]   pd_in     [4];
  logic [4:0]        rd_in     [4];
  logic [ROB_W-1:0]  rob_in    [4];
  logic [DATA_W-1:0] result_in [4];

  // Lost-arbitration counters
  logic [15:0] stall_q [4];
  logic [15:0] stall_d [4];

  // Arbitration
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [3:0] grant;
  logic [3:0] accept;

`ifdef CDB_ARB_RR_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;

  // Round-robin: the first occupied entry at or above the pointer (mod 4).
  always_comb begin
    logic [1:0] probe;
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    probe     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      probe = rr_ptr_q + 2'(k);
      if (!sel_found && hold_v_q[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  // Pointer only moves on an actual broadcast; flush and reset cycles never
  // broadcast, so flush leaves it untouched.
  assign rr_ptr_d = cdb_valid ? (sel_idx + 2'd1) : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: ascending scan, so the highest occupied index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (hold_v_q[k]) begin
        sel_found = 1'b1;
        sel_idx   = 2'(k);
      end
    end
  end
`endif

  // No broadcast while flushing or in reset.
  assign grant = (sel_found && !flush && !rst) ? (4'b0001 << sel_idx) : 4'b0000;

  // An entry being granted this cycle can take a new result at the same edge.
  assign req_ready = (rst || flush) ? 4'b0000 : (~hold_v_q | grant);
  assign accept    = req_valid & req_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign pd_in[gi]     = req_pd[gi*PD_W +: PD_W];
      assign rd_in[gi]     = req_rd[gi*5 +: 5];
      assign rob_in[gi]    = req_rob[gi*ROB_W +: ROB_W];
      assign result_in[gi] = req_result[gi*DATA_W +: DATA_W];

      // A fresh accept wins over the drain of the same entry.
      assign hold_v_d[gi] = flush        ? 1'b0 :
                            accept[gi]   ? 1'b1 :
                            grant[gi]    ? 1'b0 :
                                           hold_v_q[gi];

      assign stall_d[gi] = (hold_v_q[gi] && !grant[gi] && !flush &&
                            (stall_q[gi] != 16'hFFFF)) ?
                           (stall_q[gi] + 16'd1) : stall_q[gi];

      assign stall_cnt[gi*16 +: 16] = stall_q[gi];
    end
  endgenerate

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        stall_q[k] <= 16'd0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      for (int k = 0; k < 4; k++) begin
        stall_q[k] <= stall_d[k];
      end
    end
  end

  // Payload storage is qualified by hold_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (accept[k]) begin
        hold_pd_q[k]     <= pd_in[k];
        hold_rd_q[k]     <= rd_in[k];
        hold_rob_q[k]    <= rob_in[k];
        hold_result_q[k] <= result_in[k];
      end
    end
  end

  // Broadcast mux; every field reads zero when the bus is idle.
  always_comb begin
    cdb_valid  = |grant;
    cdb_sent   = grant;
    cdb_pd     = '0;
    cdb_rd     = '0;
    cdb_rob    = '0;
    cdb_result = '0;
    cdb_src    = 2'd0;
    if (cdb_valid) begin
      cdb_pd     = hold_pd_q[sel_idx];
      cdb_rd     = hold_rd_q[sel_idx];
      cdb_rob    = hold_rob_q[sel_idx];
      cdb_result = hold_result_q[sel_idx];
      cdb_src    = sel_idx;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
// Testbench for cdb_arbiter: vector table plus hand-written corner sequences,
// with a payload scoreboard that tracks every accepted result to its broadcast.
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int PD_W   = 6;
  localparam int ROB_W  = 5;
`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [3:0]          req_valid;
  logic [4*PD_W-1:0]   req_pd;
  logic [4*5-1:0]      req_rd;
  logic [4*ROB_W-1:0]  req_rob;
  logic [4*DATA_W-1:0] req_result;
  logic [3:0]          req_ready;
  logic                cdb_valid;
  logic [PD_W-1:0]     cdb_pd;
  logic [4:0]          cdb_rd;
  logic [ROB_W-1:0]    cdb_rob;
  logic [DATA_W-1:0]   cdb_result;
  logic [1:0]          cdb_src;
  logic [3:0]          cdb_sent;
  logic [4*16-1:0]     stall_cnt;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(DATA_W), .PD_W(PD_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_pd(req_pd), .req_rd(req_rd),
    .req_rob(req_rob), .req_result(req_result), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rd(cdb_rd),
    .cdb_rob(cdb_rob), .cdb_result(cdb_result), .cdb_src(cdb_src),
    .cdb_sent(cdb_sent), .stall_cnt(stall_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int tag      = 0;

  typedef struct {
    logic [1:0]        src;
    logic [PD_W-1:0]   pd;
    logic [4:0]        rd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] result;
  } pl_t;
  pl_t sb[$];

  typedef struct {
    logic       r;
    logic       f;
    logic [3:0] v;
    logic [3:0] exp_ready;
    logic       exp_cv;
    logic [1:0] exp_src;
  } vec_t;
  vec_t vt[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then move to the sampling point.
  task automatic apply(input logic r, input logic f, input logic [3:0] v);
    tag++;
    rst       = r;
    flush     = f;
    req_valid = v;
    for (int s = 0; s < 4; s++) begin
      req_pd[s*PD_W +: PD_W]       = PD_W'(tag * 4 + s);
      req_rd[s*5 +: 5]             = 5'(tag + s * 7);
      req_rob[s*ROB_W +: ROB_W]    = ROB_W'(tag * 3 + s);
      req_result[s*DATA_W +: DATA_W] = DATA_W'(tag * 65536 + s * 4096 + 85);
    end
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on broadcast, push on accept, drop all on flush/reset.
  always @(negedge clk) begin
    int   idx;
    pl_t  e;
    pl_t  n;
    if (cdb_valid === 1'b1) begin
      idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (idx < 0 && sb[k].src == cdb_src) idx = k;
      end
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL sb_spurious: got broadcast src=%0d expected no broadcast", cdb_src);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        if ({cdb_pd, cdb_rd, cdb_rob, cdb_result, cdb_sent} !==
            {e.pd, e.rd, e.rob, e.result, 4'b0001 << e.src}) begin
          failures++;
          $display("FAIL sb_payload src%0d: got pd=%0h rd=%0h rob=%0h res=%0h sent=%b expected pd=%0h rd=%0h rob=%0h res=%0h",
                   cdb_src, cdb_pd, cdb_rd, cdb_rob, cdb_result, cdb_sent, e.pd, e.rd, e.rob, e.result);
        end
      end
    end else begin
      checks++;
      if ({cdb_pd, cdb_rd, cdb_rob, cdb_result, cdb_src, cdb_sent} != '0) begin
        failures++;
        $display("FAIL idle_zero: got pd=%0h rd=%0h rob=%0h res=%0h src=%0d sent=%b expected all 0",
                 cdb_pd, cdb_rd, cdb_rob, cdb_result, cdb_src, cdb_sent);
      end
    end
    if (rst || flush) begin
      sb.delete();
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (req_valid[s] && req_ready[s]) begin
          n.src    = 2'(s);
          n.pd     = req_pd[s*PD_W +: PD_W];
          n.rd     = req_rd[s*5 +: 5];
          n.rob    = req_rob[s*ROB_W +: ROB_W];
          n.result = req_result[s*DATA_W +: DATA_W];
          sb.push_back(n);
        end
      end
    end
  end

  logic [63:0] exp_stall;

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 4'b0000;
    req_pd = '0; req_rd = '0; req_rob = '0; req_result = '0;

    // r f v ready cv src
    vt[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[2]  = '{1'b0, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0};
    vt[3]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0};
    vt[4]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[5]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0};
    vt[6]  = '{1'b0, 1'b0, 4'b0000, RR ? 4'b0010 : 4'b1000, 1'b1, RR ? 2'd1 : 2'd3};
    vt[7]  = '{1'b0, 1'b0, 4'b0000, RR ? 4'b0110 : 4'b1100, 1'b1, 2'd2};
    vt[8]  = '{1'b0, 1'b0, 4'b0000, 4'b1110, 1'b1, RR ? 2'd3 : 2'd1};
    vt[9]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0};
    vt[10] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[11] = '{1'b0, 1'b0, 4'b1000, 4'b1111, 1'b0, 2'd0};
    vt[12] = '{1'b0, 1'b0, 4'b1001, 4'b1111, 1'b1, 2'd3};
    vt[13] = '{1'b0, 1'b0, 4'b0000, RR ? 4'b0111 : 4'b1110, 1'b1, RR ? 2'd0 : 2'd3};
    vt[14] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, RR ? 2'd3 : 2'd0};
    vt[15] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[16] = '{1'b0, 1'b0, 4'b1011, 4'b1111, 1'b0, 2'd0};
    vt[17] = '{1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vt[18] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[19] = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0};
    vt[20] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0};
    vt[21] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[22] = '{1'b0, 1'b0, 4'b0110, 4'b1111, 1'b0, 2'd0};
    vt[23] = '{1'b0, 1'b0, 4'b0000, RR ? 4'b1011 : 4'b1101, 1'b1, RR ? 2'd1 : 2'd2};
    vt[24] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, RR ? 2'd2 : 2'd1};
    vt[25] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};

    tick();
    for (int i = 0; i < 26; i++) begin
      apply(vt[i].r, vt[i].f, vt[i].v);
      check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vt[i].exp_ready));
      check($sformatf("vec%0d_cdb_valid", i), 64'(cdb_valid), 64'(vt[i].exp_cv));
      if (vt[i].exp_cv)
        check($sformatf("vec%0d_cdb_src", i), 64'(cdb_src), 64'(vt[i].exp_src));
      $display("vec%0d r=%b f=%b v=%b ready=%b cdb_valid=%b src=%0d", i, vt[i].r, vt[i].f,
               vt[i].v, req_ready, cdb_valid, cdb_src);
      tick();
    end

    // Single ALU result with a fixed payload, then idle.
    apply(1'b1, 1'b0, 4'b0000); tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("post_rst_stall", stall_cnt, 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'hF);
    check("post_rst_sent", 64'(cdb_sent), 64'd0);
    tick();
    apply(1'b0, 1'b0, 4'b0001);
    req_pd[PD_W-1:0] = PD_W'(7);
    req_result[DATA_W-1:0] = DATA_W'(32'h1234);
    tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("alu_cdb_valid", 64'(cdb_valid), 64'd1);
    check("alu_cdb_pd", 64'(cdb_pd), 64'd7);
    check("alu_cdb_result", 64'(cdb_result), 64'h1234);
    check("alu_cdb_sent", 64'(cdb_sent), 64'b0001);
    $display("alu_single pd=%0d result=%0h sent=%b", cdb_pd, cdb_result, cdb_sent);
    tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("alu_then_idle", 64'(cdb_valid), 64'd0);
    tick();

    // Four simultaneous sources from a fresh reset (pointer 0).
    apply(1'b1, 1'b0, 4'b0000); tick();
    apply(1'b0, 1'b0, 4'b1111); tick();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 4'b0000);
      check($sformatf("four_order%0d", c), 64'(cdb_src), RR ? 64'(c) : 64'(3 - c));
      $display("four_src cycle=%0d src=%0d", c, cdb_src);
      tick();
    end
    exp_stall = RR ? 64'h0003_0002_0001_0000 : 64'h0000_0001_0002_0003;
    check("four_stall", stall_cnt, exp_stall);

    // Reset in the middle of contention.
    apply(1'b0, 1'b0, 4'b1111); tick();
    apply(1'b0, 1'b0, 4'b0000); tick();
    apply(1'b1, 1'b0, 4'b1111);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
    tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("midrst_stall", stall_cnt, 64'd0);
    check("midrst_after_cdb_valid", 64'(cdb_valid), 64'd0);
    tick();
    apply(1'b0, 1'b0, 4'b0101); tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("midrst_first_grant", 64'(cdb_src), RR ? 64'd0 : 64'd2);
    $display("midrst first grant src=%0d", cdb_src);
    tick();
    apply(1'b0, 1'b0, 4'b0000); tick();

    // Back-to-back ALU streaming.
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b0, 4'b0001);
      check($sformatf("stream%0d_ready", c), 64'(req_ready[0]), 64'd1);
      if (c > 0) check($sformatf("stream%0d_cdb_valid", c), 64'(cdb_valid), 64'd1);
      $display("stream cycle=%0d ready=%b cdb_valid=%b", c, req_ready, cdb_valid);
      tick();
    end
    apply(1'b0, 1'b0, 4'b0000);
    check("stream_last", 64'(cdb_valid), 64'd1);
    tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("stream_done", 64'(cdb_valid), 64'd0);
    tick();

    // Flush with all four holds full.
    apply(1'b0, 1'b0, 4'b1111); tick();
    apply(1'b0, 1'b1, 4'b0000);
    check("flushfull_cdb_valid", 64'(cdb_valid), 64'd0);
    check("flushfull_ready", 64'(req_ready), 64'd0);
    tick();
    apply(1'b0, 1'b0, 4'b0000);
    check("flushfull_after_valid", 64'(cdb_valid), 64'd0);
    check("flushfull_after_ready", 64'(req_ready), 64'hF);
    exp_stall = RR ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001;
    check("flushfull_stall", stall_cnt, exp_stall);
    $display("flush_full ready=%b stall=%0h", req_ready, stall_cnt);
    tick();
    apply(1'b0, 1'b0, 4'b0000); tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
